// File: rtl/sha3_byte_packer.sv
// Byte-to-word packer feeding the SHA-3 padder: bytes are packed big-endian
// into 32-bit words, ending with a flagged final word (empty when length % 4 == 0).
module sha3_byte_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   input  logic        byte_last,
   output logic        byte_ready,
   output logic [31:0] out_word,
   output logic        out_valid,
   output logic        out_last,
   output logic [1:0]  out_byte_num,
   input  logic        buffer_full
);

   localparam logic [1:0] COLLECT = 2'd0;
   localparam logic [1:0] FLUSH   = 2'd1;
   localparam logic [1:0] DONE    = 2'd2;

   logic [1:0]  state_reg;
   logic [31:0] acc_reg;
   logic [2:0]  cnt_reg;
   logic [31:0] ow_reg;
   logic        ov_reg;
   logic        ol_reg;
   logic [1:0]  obn_reg;

   logic        bfire;
   logic        wfire;
   logic [31:0] flush_word;

   // A fourth byte can only be taken once the output register is free.
   assign byte_ready = (state_reg == COLLECT) && ((cnt_reg != 3'd3) || !ov_reg);
   assign bfire      = byte_valid & byte_ready;
   assign wfire      = ov_reg & ~buffer_full;

   // Held bytes left-justified; cnt==0 yields the empty final word.
   always_comb begin
      case (cnt_reg)
         3'd1:    flush_word = {acc_reg[7:0], 24'h000000};
         3'd2:    flush_word = {acc_reg[15:0], 16'h0000};
         3'd3:    flush_word = {acc_reg[23:0], 8'h00};
         default: flush_word = 32'h00000000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= COLLECT;
         acc_reg   <= 32'h0;
         cnt_reg   <= 3'd0;
         ow_reg    <= 32'h0;
         ov_reg    <= 1'b0;
         ol_reg    <= 1'b0;
         obn_reg   <= 2'd0;
      end else begin
         // Loads below only happen when ov_reg is already 0, so they never collide with this clear.
         if (wfire)
            ov_reg <= 1'b0;

         case (state_reg)
            COLLECT: begin
               if (bfire) begin
                  if (byte_last) begin
                     acc_reg   <= {acc_reg[23:0], byte_in};
                     cnt_reg   <= cnt_reg + 3'd1;
                     state_reg <= FLUSH;
                  end else if (cnt_reg == 3'd3) begin
                     ow_reg  <= {acc_reg[23:0], byte_in};
                     ov_reg  <= 1'b1;
                     ol_reg  <= 1'b0;
                     obn_reg <= 2'd0;
                     cnt_reg <= 3'd0;
                  end else begin
                     acc_reg <= {acc_reg[23:0], byte_in};
                     cnt_reg <= cnt_reg + 3'd1;
                  end
               end
            end
            FLUSH: begin
               if (!ov_reg) begin
                  if (cnt_reg == 3'd4) begin
                     ow_reg  <= acc_reg;
                     ov_reg  <= 1'b1;
                     ol_reg  <= 1'b0;
                     obn_reg <= 2'd0;
                     cnt_reg <= 3'd0;
                  end else begin
                     ow_reg    <= flush_word;
                     obn_reg   <= cnt_reg[1:0];
                     ol_reg    <= 1'b1;
                     ov_reg    <= 1'b1;
                     state_reg <= DONE;
                  end
               end
            end
            DONE: begin
            end
            default: state_reg <= COLLECT;
         endcase
      end
   end

   assign out_valid    = ov_reg;
   assign out_word     = ov_reg ? ow_reg : 32'h0;
   assign out_byte_num = (ov_reg & ol_reg) ? obn_reg : 2'd0;
   // Gated by buffer_full: the padder latches is_last even while it refuses the word.
   assign out_last     = ov_reg & ol_reg & ~buffer_full;

endmodule

// File: tb/tb_sha3_byte_packer.sv
// Self-checking bench for sha3_byte_packer: randomized handshakes checked against
// a word-list model computed directly from the message bytes.
module tb_sha3_byte_packer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid = 1'b0;
   logic        byte_last = 1'b0;
   logic        byte_ready;
   logic [31:0] out_word;
   logic        out_valid;
   logic        out_last;
   logic [1:0]  out_byte_num;
   logic        buffer_full = 1'b0;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] word;
      logic        last;
      logic [1:0]  bn;
   } word_t;

   logic [7:0] msg_q[$];
   word_t      exp_q[$];
   word_t      got_q[$];

   sha3_byte_packer dut (
      .clk          (clk),
      .reset        (reset),
      .byte_in      (byte_in),
      .byte_valid   (byte_valid),
      .byte_last    (byte_last),
      .byte_ready   (byte_ready),
      .out_word     (out_word),
      .out_valid    (out_valid),
      .out_last     (out_last),
      .out_byte_num (out_byte_num),
      .buffer_full  (buffer_full)
   );

   always #5 clk = ~clk;

   // One cycle: drive at the falling edge, sample 1 ns later, log any word the padder takes.
   task automatic step(input logic v, input logic [7:0] b, input logic l, input logic bf,
                       output logic fired);
      word_t w;
      @(negedge clk);
      byte_valid  = v;
      byte_in     = b;
      byte_last   = l;
      buffer_full = bf;
      #1;
      fired = v & byte_ready;
      if (out_valid && !buffer_full) begin
         w.word = out_word;
         w.last = out_last;
         w.bn   = out_byte_num;
         got_q.push_back(w);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; byte_valid = 1'b0; byte_last = 1'b0; buffer_full = 1'b0; byte_in = 8'h00;
      @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   // Model: floor(n/4) full words, then one final word with n%4 left-justified bytes.
   task automatic build_expected();
      int n;
      int nf;
      word_t e;
      n  = msg_q.size();
      nf = n / 4;
      exp_q.delete();
      for (int w = 0; w < nf; w++) begin
         e.word = {msg_q[4*w], msg_q[4*w+1], msg_q[4*w+2], msg_q[4*w+3]};
         e.last = 1'b0;
         e.bn   = 2'd0;
         exp_q.push_back(e);
      end
      e.word = 32'h0;
      for (int j = 0; j < n % 4; j++)
         e.word[31-8*j -: 8] = msg_q[4*nf+j];
      e.last = 1'b1;
      e.bn   = 2'(n % 4);
      exp_q.push_back(e);
   endtask

   // Sends msg_q with random gaps/back-pressure and drains until the final word is taken.
   task automatic drive_message(input int pv, input int pbf, output logic timed_out);
      int idx;
      int cyc;
      logic fired;
      logic v;
      logic bf;
      idx = 0;
      cyc = 0;
      got_q.delete();
      build_expected();
      while (idx < msg_q.size() && cyc < 2000) begin
         v  = ($urandom_range(99) < pv);
         bf = ($urandom_range(99) < pbf);
         step(v, v ? msg_q[idx] : 8'($urandom), v && (idx == msg_q.size() - 1), bf, fired);
         if (fired) idx++;
         cyc++;
      end
      while ((got_q.size() == 0 || !got_q[got_q.size()-1].last) && cyc < 2000) begin
         bf = ($urandom_range(99) < pbf);
         step(1'b0, 8'($urandom), 1'b0, bf, fired);
         cyc++;
      end
      timed_out = (cyc >= 2000);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (byte_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 ||
          out_word !== 32'h0 || out_byte_num !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: got ready=%b valid=%b last=%b word=%h bn=%0d, expected 1 0 0 00000000 0",
                  byte_ready, out_valid, out_last, out_word, out_byte_num);
      end
   endtask

   task automatic test_known_messages();
      logic to;
      logic fired;
      for (int m = 0; m < 2; m++) begin
         do_reset();
         msg_q.delete();
         if (m == 0) for (int i = 1; i <= 8; i++) msg_q.push_back(8'(i));
         else        for (int i = 1; i <= 5; i++) msg_q.push_back(8'(8'hA0 + i));
         drive_message(100, 0, to);
         checks++;
         if (to) begin errors++; $display("FAIL known_timeout msg%0d: final word never taken", m); end
         checks++;
         if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL known_count msg%0d: got %0d words, expected %0d", m, got_q.size(), exp_q.size());
         end
         for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i].word !== exp_q[i].word || got_q[i].last !== exp_q[i].last ||
                got_q[i].bn !== exp_q[i].bn) begin
               errors++;
               $display("FAIL known_word msg%0d[%0d]: got %h last=%b bn=%0d, expected %h last=%b bn=%0d", m, i,
                        got_q[i].word, got_q[i].last, got_q[i].bn, exp_q[i].word, exp_q[i].last, exp_q[i].bn);
            end
         end
         step(1'b1, 8'hFF, 1'b0, 1'b0, fired);
         checks++;
         if (byte_ready !== 1'b0 || out_valid !== 1'b0 || out_word !== 32'h0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL done_idle msg%0d: got ready=%b valid=%b word=%h last=%b, expected 0 0 0 0",
                     m, byte_ready, out_valid, out_word, out_last);
         end
      end
   endtask

   task automatic test_last_held();
      logic fired;
      int   waitc;
      do_reset();
      step(1'b1, 8'hC1, 1'b0, 1'b0, fired);
      step(1'b1, 8'hC2, 1'b0, 1'b0, fired);
      step(1'b1, 8'hC3, 1'b1, 1'b1, fired);
      waitc = 0;
      do begin
         step(1'b0, 8'h00, 1'b0, 1'b1, fired);
         waitc++;
      end while (!out_valid && waitc < 10);
      for (int c = 0; c < 10; c++) begin
         if (c > 0) step(1'b0, 8'h00, 1'b0, 1'b1, fired);
         checks++;
         if (out_valid !== 1'b1 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL held_last cycle %0d: got valid=%b last=%b, expected 1 0", c, out_valid, out_last);
         end
      end
      step(1'b0, 8'h00, 1'b0, 1'b0, fired);
      checks++;
      if (out_last !== 1'b1 || out_word !== 32'hC1C2C300 || out_byte_num !== 2'd3) begin
         errors++;
         $display("FAIL held_release: got last=%b word=%h bn=%0d, expected 1 c1c2c300 3",
                  out_last, out_word, out_byte_num);
      end
      step(1'b0, 8'h00, 1'b0, 1'b0, fired);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL held_after_fire: got valid=%b, expected 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      logic fired;
      int   acc_n;
      do_reset();
      acc_n = 0;
      for (int i = 1; i <= 7; i++) begin
         step(1'b1, 8'(8'h10 + i), 1'b0, 1'b1, fired);
         if (fired) acc_n++;
      end
      checks++;
      if (acc_n != 7) begin
         errors++;
         $display("FAIL bp_accept: got %0d bytes accepted, expected 7", acc_n);
      end
      acc_n = 0;
      for (int c = 0; c < 5; c++) begin
         step(1'b1, 8'h18, 1'b1, 1'b1, fired);
         if (fired) acc_n++;
      end
      checks++;
      if (acc_n != 0) begin
         errors++;
         $display("FAIL bp_stall: got %0d bytes accepted while full, expected 0", acc_n);
      end
      step(1'b1, 8'h18, 1'b1, 1'b0, fired);
      checks++;
      if (fired !== 1'b0 || out_word !== 32'h11121314 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: got ready=%b valid=%b word=%h, expected 0 1 11121314",
                  fired, out_valid, out_word);
      end
      step(1'b1, 8'h18, 1'b1, 1'b0, fired);
      checks++;
      if (fired !== 1'b1) begin
         errors++;
         $display("FAIL bp_resume: got ready=%b, expected 1", fired);
      end
   endtask

   task automatic test_reset_mid();
      logic fired;
      logic to;
      do_reset();
      for (int i = 1; i <= 6; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b1, fired);
      do_reset();
      checks++;
      if (byte_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 ||
          out_word !== 32'h0 || out_byte_num !== 2'd0) begin
         errors++;
         $display("FAIL midreset_state: got ready=%b valid=%b last=%b word=%h bn=%0d, expected 1 0 0 00000000 0",
                  byte_ready, out_valid, out_last, out_word, out_byte_num);
      end
      msg_q.delete();
      msg_q.push_back(8'h11); msg_q.push_back(8'h22); msg_q.push_back(8'h33);
      drive_message(100, 0, to);
      checks++;
      if (to || got_q.size() != 1) begin
         errors++;
         $display("FAIL midreset_count: got %0d words timeout=%b, expected 1 0", got_q.size(), to);
      end else begin
         checks++;
         if (got_q[0].word !== exp_q[0].word || got_q[0].last !== 1'b1 || got_q[0].bn !== 2'd3) begin
            errors++;
            $display("FAIL midreset_word: got %h last=%b bn=%0d, expected %h 1 3",
                     got_q[0].word, got_q[0].last, got_q[0].bn, exp_q[0].word);
         end
      end
   endtask

   task automatic test_random();
      logic to;
      int   len;
      for (int t = 0; t < 8; t++) begin
         do_reset();
         len = (t < 4) ? 4 * (t + 1) : $urandom_range(1, 21);
         msg_q.delete();
         for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
         drive_message(70, 35, to);
         checks++;
         if (to || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count t%0d len=%0d: got %0d words timeout=%b, expected %0d",
                     t, len, got_q.size(), to, exp_q.size());
         end
         for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i].word !== exp_q[i].word || got_q[i].last !== exp_q[i].last ||
                got_q[i].bn !== exp_q[i].bn) begin
               errors++;
               $display("FAIL rand_word t%0d[%0d]: got %h last=%b bn=%0d, expected %h last=%b bn=%0d", t, i,
                        got_q[i].word, got_q[i].last, got_q[i].bn, exp_q[i].word, exp_q[i].last, exp_q[i].bn);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_known_messages();
      test_last_held();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
